// File: rtl/display_scan_driver_pkg.sv
// Shared types and sizes for the display scan driver.
// Digit-state enum, bus widths and small frame helpers.
package display_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int CODE_W     = 4;
  localparam int IDX_W      = 2;
  localparam int FRAME_W    = NUM_DIGITS * CODE_W;

  function automatic logic [CODE_W-1:0] digit_sel(
    input logic [FRAME_W-1:0] frame,
    input logic [IDX_W-1:0]   idx
  );
    return frame[idx*CODE_W +: CODE_W];
  endfunction

  function automatic logic [NUM_DIGITS-1:0] onehot_low(
    input logic [IDX_W-1:0] idx
  );
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Frame hand-off channel from the control logic to the scan driver.
// Producer drives valid/data, the driver answers with ready.
interface display_scan_driver_if;
  import display_pkg::*;

  logic               frame_valid_i;
  logic               frame_ready_o;
  logic [FRAME_W-1:0] frame_data_i;

  modport master (
    output frame_valid_i,
    output frame_data_i,
    input  frame_ready_o
  );

  modport slave (
    input  frame_valid_i,
    input  frame_data_i,
    output frame_ready_o
  );

endinterface

// File: rtl/display_scan_driver_scan_timer.sv
// Per-state dwell counter for the scan FSM.
// Counts up to a supplied limit; hold freezes, clr restarts at zero.
module scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: freeze wins over restart, otherwise step
  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/display_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with blanking gaps.
// Frames are double-buffered and swapped only at frame boundaries.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  display_scan_driver_if.slave  frame,
  output logic [CODE_W-1:0]     code_o,
  output logic [NUM_DIGITS-1:0] digit_en_n_o,
  output logic [IDX_W-1:0]      digit_idx_o,
  output logic                  frame_done_o
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ?
                        SHOW_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(MAXC);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS-1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   active_q, active_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
  logic                 done_q, done_d;

  logic [TW-1:0]        cnt;
  logic [TW-1:0]        limit;
  logic                 tc;
  logic                 hold;
  logic                 adv;
  logic                 boundary;
  logic                 accept;

  assign limit = (state_q == ST_SHOW) ?
                 TW'(SHOW_CYCLES - 1) :
                 TW'(BLANK_CYCLES - 1);
  assign hold  = ~en_i;

  scan_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tc),
    .hold    (hold),
    .limit_i (limit),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  assign adv      = en_i & tc;
  assign boundary = adv & (state_q == ST_SHOW) &
                    (idx_q == LAST_IDX);
  assign accept   = frame.frame_valid_i & ~pending_q;

  // state/index/buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      code_q    <= '0;
      en_n_q    <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      en_n_q    <= en_n_d;
      done_q    <= done_d;
    end
  end

  // next state, digit advance and frame double-buffer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (adv) begin
      unique case (state_q)
        ST_BLANK: state_d = ST_SHOW;
        ST_SHOW: begin
          state_d = ST_BLANK;
          idx_d   = idx_q + IDX_W'(1);
        end
        default: state_d = ST_BLANK;
      endcase
    end
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = frame.frame_data_i;
      pending_d = 1'b1;
    end
  end

  // outputs follow the next state so they line up with it
  always_comb begin
    code_d = digit_sel(active_d, idx_d);
    en_n_d = '1;
    done_d = 1'b0;
    unique case (1'b1)
      (en_i && state_d == ST_SHOW): en_n_d = onehot_low(idx_d);
      default:                      en_n_d = '1;
    endcase
    done_d = en_i && (state_q == ST_SHOW) &&
             (idx_q == LAST_IDX) &&
             (cnt == TW'(SHOW_CYCLES - 2));
  end

  assign code_o              = code_q;
  assign digit_en_n_o        = en_n_q;
  assign digit_idx_o         = idx_q;
  assign frame_done_o        = done_q;
  assign frame.frame_ready_o = ~pending_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for the display scan driver.
// A frame-position model predicts every cycle of the scan.
module tb_display_scan_driver;

  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = SHOW + BLANK;
  localparam int PER   = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic [3:0] code_o;
  logic [3:0] digit_en_n_o;
  logic [1:0] digit_idx_o;
  logic       frame_done_o;

  display_scan_driver_if fif();

  display_scan_driver #(
    .SHOW_CYCLES  (SHOW),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .frame        (fif.slave),
    .code_o       (code_o),
    .digit_en_n_o (digit_en_n_o),
    .digit_idx_o  (digit_idx_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] en_n;
    logic [1:0] idx;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  int          pos;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;

  // one clock of stimulus; model predicts the post-edge outputs
  task automatic step(input bit r, input bit e,
                      input bit v, input logic [15:0] d);
    exp_t x;
    bit   acc;
    int   dig;
    bit   show;
    rst_n = r;
    en_i  = e;
    fif.frame_valid_i = v;
    fif.frame_data_i  = d;
    if (!r) begin
      pos = 0;
      m_active = '0;
      m_shadow = '0;
      m_pending = 1'b0;
    end else begin
      acc = v && !m_pending;
      if (e) begin
        if (pos == PER - 1) begin
          pos = 0;
          if (m_pending) begin
            m_active = m_shadow;
            m_pending = 1'b0;
          end
        end else begin
          pos = pos + 1;
        end
      end
      if (acc) begin
        m_shadow = d;
        m_pending = 1'b1;
      end
    end
    dig  = pos / SLOT;
    show = (pos % SLOT) >= BLANK;
    x.code  = m_active[dig*4 +: 4];
    x.en_n  = (r && e && show) ? ~(4'b0001 << dig) : 4'hF;
    x.idx   = 2'(dig);
    x.done  = r && e && (pos == PER - 1);
    x.ready = !m_pending;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 16'($urandom));
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * PER && pos != p; i++)
      step(1, 1, 0, 16'($urandom));
    n_chk++;
    if (pos != p) begin
      n_fail++;
      $display("FAIL wait_pos got=%0d want=%0d", pos, p);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3 * PER && m_pending; i++)
      step(1, 1, 0, 16'($urandom));
    n_chk++;
    if (m_pending) begin
      n_fail++;
      $display("FAIL wait_ready got=pending want=free");
    end
  endtask

  // monitor: compare one expectation per clock, mid-cycle
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {code_o, digit_en_n_o, digit_idx_o,
           frame_done_o, fif.frame_ready_o};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scan cyc=%0d got code=%h en_n=%h idx=%0d done=%b rdy=%b want code=%h en_n=%h idx=%0d done=%b rdy=%b",
                 cyc, a.code, a.en_n, a.idx, a.done, a.ready,
                 e.code, e.en_n, e.idx, e.done, e.ready);
      end
    end
  end

  initial begin
    fif.frame_valid_i = 1'b0;
    fif.frame_data_i  = '0;
    rst_n = 1'b0;
    en_i  = 1'b0;

    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);

    step(1, 1, 1, 16'h4321);
    run(2 * PER + 3);

    wait_pos(8);
    step(1, 1, 1, 16'h9876);
    step(1, 1, 1, 16'hAAAA);
    run(5);
    step(1, 1, 1, 16'hAAAA);
    wait_ready();
    step(1, 1, 1, 16'h1357);
    run(2 * PER);

    wait_pos(15);
    for (int i = 0; i < 10; i++)
      step(1, 0, ($urandom_range(0, 3) == 0), 16'($urandom));
    run(PER + 5);

    wait_ready();
    step(1, 1, 1, 16'hBEEF);
    wait_pos(9);
    step(0, 1, 0, 16'h0);
    run(PER + 4);

    for (int i = 0; i < 500; i++)
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0),
           16'($urandom));

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
